// File: rtl/gfx_pkg.sv
// gfx_pkg: shared state encoding, coordinate widths and zero-extension helper
package gfx_pkg;
  localparam int X_W = 10;
  localparam int Y_W = 9;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  function automatic logic [31:0] zext(input logic [X_W-1:0] v);
    return {{(32-X_W){1'b0}}, v};
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first set request at or after ptr, wrapping
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] id
);
  localparam int ID_W = $clog2(NUM_REQ);
  logic [ID_W-1:0] idx;
  always_comb begin
    id = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      id = req[idx] ? idx : id;
    end
    gnt = |req ? NUM_REQ'(1) << id : '0;
  end
endmodule

// File: rtl/line_cmd_sched.sv
// line_cmd_sched: round-robin scheduler sharing one Bresenham engine, normalising
// endpoints and forwarding de-duplicated, colour-tagged pixel writes
module line_cmd_sched
  import gfx_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int COLOR_W = 8,
  parameter int TIMEOUT = 2048
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*X_W-1:0]       req_x1,
  input  logic [NUM_REQ*X_W-1:0]       req_x2,
  input  logic [NUM_REQ*Y_W-1:0]       req_y1,
  input  logic [NUM_REQ*Y_W-1:0]       req_y2,
  input  logic [NUM_REQ*COLOR_W-1:0]   req_color,
  output logic [NUM_REQ-1:0]           gnt,
  output logic                         done,
  output logic                         err,
  output logic [$clog2(NUM_REQ)-1:0]   done_id,
  output logic                         busy,
  output logic                         eng_start,
  output logic [31:0]                  eng_x1,
  output logic [31:0]                  eng_y1,
  output logic [31:0]                  eng_x2,
  output logic [31:0]                  eng_y2,
  input  logic                         eng_finish,
  input  logic [X_W-1:0]               eng_X,
  input  logic [Y_W-1:0]               eng_Y,
  output logic                         pix_we,
  output logic [X_W-1:0]               pix_x,
  output logic [Y_W-1:0]               pix_y,
  output logic [COLOR_W-1:0]           pix_color
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);
  state_t state, nstate;
  logic [ID_W-1:0] ptr, lid, aid;
  logic [NUM_REQ-1:0] agnt;
  logic [X_W-1:0] lx1, lx2;
  logic [Y_W-1:0] ly1, ly2;
  logic [COLOR_W-1:0] lcol;
  logic [CW-1:0] cnt;
  logic err_q, first, cool, take, swap, mixed, fin, wr;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (.req(req), .ptr(ptr), .gnt(agnt), .id(aid));
  // cool blocks arbitration for the first IDLE cycle after DONE
  assign take = state == IDLE && |req && !cool;
  assign swap = lx2 < lx1 && ly2 < ly1;
  assign mixed = (lx2 < lx1) ^ (ly2 < ly1);
  assign fin = eng_finish && cnt != '0;
  // pix_x/pix_y hold the last written pixel, so they double as the de-dup reference
  assign wr = state == RUN && cnt != '0 && !eng_finish && (first || eng_X != pix_x || eng_Y != pix_y);
  assign busy = state != IDLE;
  assign eng_start = state != RUN;
  assign done = state == DONE;
  assign err = done && err_q;
  assign done_id = lid;
  assign eng_x1 = zext(swap ? lx2 : lx1);
  assign eng_x2 = zext(swap ? lx1 : lx2);
  assign eng_y1 = zext(X_W'(swap ? ly2 : ly1));
  assign eng_y2 = zext(X_W'(swap ? ly1 : ly2));
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    nstate = take ? LOAD : IDLE;
      LOAD:    nstate = mixed ? DONE : RUN;
      RUN:     nstate = (fin || cnt == CW'(TIMEOUT - 1)) ? DONE : RUN;
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      lid <= '0;
      gnt <= '0;
      lx1 <= '0;
      lx2 <= '0;
      ly1 <= '0;
      ly2 <= '0;
      lcol <= '0;
      cnt <= '0;
      err_q <= 1'b0;
      first <= 1'b1;
      cool <= 1'b0;
      pix_we <= 1'b0;
      pix_x <= '0;
      pix_y <= '0;
      pix_color <= '0;
    end else begin
      state <= nstate;
      cool <= state == DONE;
      gnt <= take ? agnt : '0;
      if (take) begin
        lid <= aid;
        lx1 <= req_x1[int'(aid)*X_W +: X_W];
        lx2 <= req_x2[int'(aid)*X_W +: X_W];
        ly1 <= req_y1[int'(aid)*Y_W +: Y_W];
        ly2 <= req_y2[int'(aid)*Y_W +: Y_W];
        lcol <= req_color[int'(aid)*COLOR_W +: COLOR_W];
      end
      cnt <= state == RUN ? cnt + 1'b1 : '0;
      err_q <= state == LOAD ? mixed : state == RUN ? !fin : err_q;
      first <= state == RUN ? first && !wr : 1'b1;
      pix_we <= wr;
      if (wr) begin
        pix_x <= eng_X;
        pix_y <= eng_Y;
        pix_color <= lcol;
      end
      if (state == DONE) ptr <= lid == ID_W'(NUM_REQ - 1) ? '0 : lid + 1'b1;
    end
  end
endmodule
